// File: rtl/id_ctrl_pkg.sv
// Shared types and helpers for the decode-stage issue controller.
// Holds the FSM state enum, default register geometry and a onehot decoder.
package id_ctrl_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_BITS = 5;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } id_state_t;

  function automatic logic [NUM_REGS-1:0] onehot(
    input logic [REG_BITS-1:0] idx
  );
    logic [NUM_REGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Per-register pending-write scoreboard with same-cycle writeback bypass.
// Register 0 is never tracked; an issue set wins over a coincident clear.
import id_ctrl_pkg::*;

module id_scoreboard #(
  parameter int NumRegs = NUM_REGS,
  parameter int RegBits = REG_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_wbe,
  input  logic [RegBits-1:0] i_wb_rdn,
  input  logic               i_set,
  input  logic [RegBits-1:0] i_rdn,
  input  logic [RegBits-1:0] i_rs1n,
  input  logic [RegBits-1:0] i_rs2n,
  output logic [NumRegs-1:0] o_busy_vec,
  output logic               o_busy_rs1,
  output logic               o_busy_rs2,
  output logic               o_busy_rd
);

  logic [NumRegs-1:0] r_busy;
  logic [NumRegs-1:0] w_clr;
  logic [NumRegs-1:0] w_set;
  logic [NumRegs-1:0] w_eff;
  logic [NumRegs-1:0] w_next;

  assign w_clr = i_wbe
    ? NumRegs'(onehot(REG_BITS'(i_wb_rdn)))
    : '0;

  assign w_set = (i_set && (i_rdn != '0))
    ? NumRegs'(onehot(REG_BITS'(i_rdn)))
    : '0;

  // Regfile writes before decode reads, so a same-cycle writeback is visible.
  assign w_eff  = r_busy & ~w_clr;
  assign w_next = (w_eff | w_set) & ~NumRegs'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_next;
    end
  end

  assign o_busy_vec = r_busy;
  assign o_busy_rs1 = w_eff[i_rs1n];
  assign o_busy_rs2 = w_eff[i_rs2n];
  assign o_busy_rd  = w_eff[i_rdn];

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: hazard stall, branch flush bubbles
// and a sticky stall watchdog around the pending-write scoreboard.
import id_ctrl_pkg::*;

module id_issue_ctrl #(
  parameter int NumRegs     = NUM_REGS,
  parameter int RegBits     = REG_BITS,
  parameter int FlushCycles = 1,
  parameter int StallLimit  = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [RegBits-1:0] rs1n,
  input  logic [RegBits-1:0] rs2n,
  input  logic [RegBits-1:0] rdn,
  input  logic               uses_rs1,
  input  logic               uses_rs2,
  input  logic               writes_rd,
  input  logic               ex_ready,
  input  logic               branch_taken,
  input  logic               wbe,
  input  logic [RegBits-1:0] wb_rdn,
  output logic               issue,
  output logic               stall,
  output logic               flush,
  output logic [NumRegs-1:0] busy_vec,
  output logic               stall_timeout
);

  localparam int FW = (FlushCycles > 1) ? $clog2(FlushCycles) : 1;
  localparam int SW = $clog2(StallLimit + 1);

  id_state_t     r_state;
  id_state_t     w_state_nx;
  logic [FW-1:0] r_fcnt;
  logic [FW-1:0] w_fcnt_nx;
  logic [SW-1:0] r_scnt;
  logic          r_timeout;

  logic w_b1;
  logic w_b2;
  logic w_bd;
  logic w_haz;
  logic w_issue;
  logic w_stall;
  logic w_flush;

  id_scoreboard #(
    .NumRegs (NumRegs),
    .RegBits (RegBits)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_wbe      (wbe),
    .i_wb_rdn   (wb_rdn),
    .i_set      (w_issue & writes_rd),
    .i_rdn      (rdn),
    .i_rs1n     (rs1n),
    .i_rs2n     (rs2n),
    .o_busy_vec (busy_vec),
    .o_busy_rs1 (w_b1),
    .o_busy_rs2 (w_b2),
    .o_busy_rd  (w_bd)
  );

  assign w_haz = id_valid & (
      (uses_rs1  & (rs1n != '0) & w_b1)
    | (uses_rs2  & (rs2n != '0) & w_b2)
    | (writes_rd & (rdn  != '0) & w_bd));

  always_comb begin
    w_state_nx = r_state;
    w_fcnt_nx  = r_fcnt;
    w_issue    = 1'b0;
    w_stall    = 1'b0;
    w_flush    = 1'b0;
    unique case (r_state)
      RUN: begin
        w_issue = id_valid & ~w_haz & ex_ready;
        w_stall = id_valid & ~w_issue;
        if (w_issue && branch_taken && (FlushCycles > 0)) begin
          w_state_nx = FLUSH;
          w_fcnt_nx  = FW'(FlushCycles - 1);
        end
      end
      FLUSH: begin
        w_flush = 1'b1;
        if (r_fcnt == '0) begin
          w_state_nx = RUN;
        end else begin
          w_fcnt_nx = r_fcnt - 1'b1;
        end
      end
      default: begin
        w_state_nx = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_fcnt  <= w_fcnt_nx;
    end
  end

  // Timeout fires on the edge where the run length reaches StallLimit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scnt    <= '0;
      r_timeout <= 1'b0;
    end else if (w_stall) begin
      if (r_scnt != SW'(StallLimit)) begin
        r_scnt <= r_scnt + 1'b1;
      end
      if (r_scnt == SW'(StallLimit - 1)) begin
        r_timeout <= 1'b1;
      end
    end else begin
      r_scnt <= '0;
    end
  end

  assign issue         = w_issue;
  assign stall         = w_stall;
  assign flush         = w_flush;
  assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed vector bench for id_issue_ctrl.
// Table rows cover scoreboard/hazard cycles; sequences cover flush and watchdog.
module tb_id_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  rs1n;
  logic [4:0]  rs2n;
  logic [4:0]  rdn;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        writes_rd;
  logic        ex_ready;
  logic        branch_taken;
  logic        wbe;
  logic [4:0]  wb_rdn;
  logic        issue;
  logic        stall;
  logic        flush;
  logic [31:0] busy_vec;
  logic        stall_timeout;

  int errors = 0;
  int checks = 0;

  id_issue_ctrl #(
    .NumRegs     (32),
    .RegBits     (5),
    .FlushCycles (2),
    .StallLimit  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .rs1n          (rs1n),
    .rs2n          (rs2n),
    .rdn           (rdn),
    .uses_rs1      (uses_rs1),
    .uses_rs2      (uses_rs2),
    .writes_rd     (writes_rd),
    .ex_ready      (ex_ready),
    .branch_taken  (branch_taken),
    .wbe           (wbe),
    .wb_rdn        (wb_rdn),
    .issue         (issue),
    .stall         (stall),
    .flush         (flush),
    .busy_vec      (busy_vec),
    .stall_timeout (stall_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  r1, r2, rd;
    logic        u1, u2, wr, rdy, br, we;
    logic [4:0]  wrn;
    logic        e_iss, e_stl, e_fl;
    logic [31:0] e_busy;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(
    input logic v, input logic [4:0] r1, input logic [4:0] r2,
    input logic [4:0] rd, input logic u1, input logic u2,
    input logic wr, input logic rdy, input logic br, input logic we,
    input logic [4:0] wrn, input logic ei, input logic es,
    input logic ef, input logic [31:0] eb
  );
    vec_t t;
    t.v = v; t.r1 = r1; t.r2 = r2; t.rd = rd;
    t.u1 = u1; t.u2 = u2; t.wr = wr; t.rdy = rdy;
    t.br = br; t.we = we; t.wrn = wrn;
    t.e_iss = ei; t.e_stl = es; t.e_fl = ef; t.e_busy = eb;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic wr,
                       input logic rdy, input logic br, input logic we,
                       input logic [4:0] wrn);
    id_valid = v; rs1n = r1; rs2n = r2; rdn = rd;
    uses_rs1 = u1; uses_rs2 = u2; writes_rd = wr;
    ex_ready = rdy; branch_taken = br; wbe = we; wb_rdn = wrn;
  endtask

  // Advance to just after the next edge, apply inputs, settle.
  task automatic cyc(input logic v, input logic [4:0] rd, input logic wr,
                     input logic rdy, input logic br, input logic we,
                     input logic [4:0] wrn);
    @(posedge clk);
    #1;
    drive(v, 5'd0, 5'd0, rd, 1'b0, 1'b0, wr, rdy, br, we, wrn);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = mk(1, 3, 4, 5, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 32'h0);
    tbl[1]  = mk(1, 5, 0, 6, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 32'h20);
    tbl[2]  = mk(1, 5, 0, 6, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 32'h20);
    tbl[3]  = mk(1, 5, 0, 6, 1, 0, 1, 1, 0, 1, 5, 1, 0, 0, 32'h20);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h40);
    tbl[5]  = mk(1, 0, 0, 6, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 32'h40);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 6, 0, 0, 0, 32'h40);
    tbl[7]  = mk(1, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 32'h0);
    tbl[8]  = mk(1, 0, 0, 7, 0, 0, 1, 1, 0, 1, 7, 1, 0, 0, 32'h80);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 32'h80);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3, 0, 0, 0, 32'h80);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 7, 0, 0, 0, 32'h80);
    tbl[12] = mk(1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_issue", issue, 0);
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_busy", busy_vec, 0);
    chk("rst_tmo", stall_timeout, 0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].v, tbl[i].r1, tbl[i].r2, tbl[i].rd, tbl[i].u1,
            tbl[i].u2, tbl[i].wr, tbl[i].rdy, tbl[i].br, tbl[i].we,
            tbl[i].wrn);
      #1;
      chk($sformatf("v%0d_issue", i), issue, tbl[i].e_iss);
      chk($sformatf("v%0d_stall", i), stall, tbl[i].e_stl);
      chk($sformatf("v%0d_flush", i), flush, tbl[i].e_fl);
      chk($sformatf("v%0d_busy", i), busy_vec, tbl[i].e_busy);
    end

    // Taken branch: two bubbles, branch pulse in FLUSH ignored.
    cyc(1, 9, 1, 1, 1, 0, 0);
    chk("br_issue", issue, 1);
    chk("br_flush", flush, 0);
    cyc(1, 0, 0, 1, 1, 0, 0);
    chk("fl1_flush", flush, 1);
    chk("fl1_issue", issue, 0);
    chk("fl1_stall", stall, 0);
    chk("fl1_busy", busy_vec, 32'h200);
    cyc(1, 0, 0, 1, 0, 1, 9);
    chk("fl2_flush", flush, 1);
    chk("fl2_issue", issue, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    chk("fl_end_flush", flush, 0);
    chk("fl_end_issue", issue, 1);
    chk("fl_wb_busy", busy_vec, 0);

    // Back-pressure watchdog.
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk($sformatf("wd%0d_stall", k), stall, 1);
      chk($sformatf("wd%0d_tmo", k), stall_timeout, 0);
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("wd_tmo_set", stall_timeout, 1);
    cyc(1, 0, 0, 1, 0, 0, 0);
    chk("wd_ready_issue", issue, 1);
    chk("wd_ready_tmo", stall_timeout, 1);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("wd_hold_tmo", stall_timeout, 1);

    // Build busy=0x0F0, branch into FLUSH, then reset.
    for (int r = 4; r < 8; r++) begin
      cyc(1, 5'(r), 1, 1, 0, 0, 0);
      chk($sformatf("fill%0d_issue", r), issue, 1);
    end
    cyc(1, 0, 0, 1, 1, 0, 0);
    chk("rb_issue", issue, 1);
    chk("rb_busy", busy_vec, 32'h0F0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    chk("rf_flush", flush, 1);
    rst = 1'b1;
    cyc(0, 0, 0, 1, 0, 1, 5);
    rst = 1'b0;
    chk("rf_busy", busy_vec, 0);
    chk("rf_flush0", flush, 0);
    chk("rf_tmo", stall_timeout, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    chk("rf_run_issue", issue, 1);
    chk("rf_run_busy", busy_vec, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
